// File: rtl/ic_fetch.sv
// Instruction-fetch stage: issues one request at a time, holds the fetched item
// for the decode stage, and redirects on flush (highest priority) or taken branch.
module ic_fetch #(
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
  parameter int          EXC_ADEL_BIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        br_e_i,
  input  logic [31:0] br_addr_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [64:0] ic_to_id_bus_o,
  output logic [31:0] ic_inst_o,
  output logic        stallreq_ic_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] exc_q, exc_d;
  logic        flush_pend_q, flush_pend_d;
  logic [31:0] flush_addr_q, flush_addr_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_addr_q, br_addr_d;
  logic        cancel_q, cancel_d;
  logic        inst_req_s;
  logic        redirect_s;
  logic [31:0] flush_tgt_s;

  // State and context registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      inst_buf_q   <= 32'h0000_0000;
      exc_q        <= 32'h0000_0000;
      flush_pend_q <= 1'b0;
      flush_addr_q <= 32'h0000_0000;
      br_pend_q    <= 1'b0;
      br_addr_q    <= 32'h0000_0000;
      cancel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_buf_q   <= inst_buf_d;
      exc_q        <= exc_d;
      flush_pend_q <= flush_pend_d;
      flush_addr_q <= flush_addr_d;
      br_pend_q    <= br_pend_d;
      br_addr_q    <= br_addr_d;
      cancel_q     <= cancel_d;
    end
  end

  // Next-state logic: redirect capture first, then per-state transitions.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_buf_d   = inst_buf_q;
    exc_d        = exc_q;
    flush_pend_d = flush_pend_q;
    flush_addr_d = flush_addr_q;
    br_pend_d    = br_pend_q;
    br_addr_d    = br_addr_q;
    cancel_d     = cancel_q;
    inst_req_s   = 1'b0;
    redirect_s   = 1'b0;
    flush_tgt_s  = flush_i ? new_pc_i : flush_addr_q;

    if (flush_i) begin
      flush_pend_d = 1'b1;
      flush_addr_d = new_pc_i;
    end else if (br_e_i && !flush_pend_q) begin
      br_pend_d = 1'b1;
      br_addr_d = br_addr_i;
    end else begin
      br_pend_d = br_pend_q;
    end

    case (state_q)
      IDLE: begin
        if (fetch_pc_q[1:0] != 2'b00) begin
          if (flush_i) begin
            redirect_s = 1'b1;
          end else begin
            state_d    = DONE;
            exc_d      = 32'h0000_0001 << EXC_ADEL_BIT;
            inst_buf_d = 32'h0000_0000;
          end
        end else begin
          inst_req_s = 1'b1;
          cancel_d   = flush_i;
          state_d    = inst_addr_ok_i ? WAIT_DATA : WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        inst_req_s = 1'b1;
        cancel_d   = cancel_q | flush_i;
        if (inst_addr_ok_i) begin
          state_d = WAIT_DATA;
        end else begin
          state_d = WAIT_ADDR;
        end
      end
      WAIT_DATA: begin
        cancel_d = cancel_q | flush_i;
        if (inst_data_ok_i) begin
          if (cancel_q || flush_i) begin
            redirect_s = 1'b1;
          end else begin
            inst_buf_d = inst_rdata_i;
            exc_d      = 32'h0000_0000;
            state_d    = DONE;
          end
        end else begin
          state_d = WAIT_DATA;
        end
      end
      DONE: begin
        if (flush_i) begin
          redirect_s = 1'b1;
        end else if (!stall_i[1]) begin
          state_d      = IDLE;
          flush_pend_d = 1'b0;
          br_pend_d    = 1'b0;
          if (flush_pend_q) begin
            fetch_pc_d = flush_addr_q;
          end else if (br_e_i) begin
            fetch_pc_d = br_addr_i;
          end else if (br_pend_q) begin
            fetch_pc_d = br_addr_q;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A cancelled or dropped fetch restarts at the flush target; any branch is superseded.
    if (redirect_s) begin
      state_d      = IDLE;
      fetch_pc_d   = flush_tgt_s;
      flush_pend_d = 1'b0;
      br_pend_d    = 1'b0;
      cancel_d     = 1'b0;
    end else begin
      cancel_d = cancel_d;
    end
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    inst_req_o     = 1'b0;
    inst_addr_o    = 32'h0000_0000;
    ic_to_id_bus_o = 65'h0;
    ic_inst_o      = 32'h0000_0000;
    stallreq_ic_o  = 1'b0;
    if (!rst_i) begin
      inst_req_o    = inst_req_s;
      inst_addr_o   = inst_req_s ? fetch_pc_q : 32'h0000_0000;
      stallreq_ic_o = (state_q != DONE);
      if (state_q == DONE) begin
        ic_to_id_bus_o = {exc_q, 1'b1, fetch_pc_q};
        ic_inst_o      = inst_buf_q;
      end else begin
        ic_to_id_bus_o = 65'h0;
      end
    end else begin
      inst_req_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ic_fetch.sv
// Directed bench for ic_fetch: inputs driven and outputs sampled on the falling edge.
module tb_ic_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_e;
  logic [31:0] br_addr;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [64:0] bus;
  logic [31:0] ic_inst;
  logic        stallreq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ic_fetch dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .flush_i        (flush),
    .new_pc_i       (new_pc),
    .br_e_i         (br_e),
    .br_addr_i      (br_addr),
    .inst_req_o     (inst_req),
    .inst_addr_o    (inst_addr),
    .inst_addr_ok_i (addr_ok),
    .inst_data_ok_i (data_ok),
    .inst_rdata_i   (rdata),
    .ic_to_id_bus_o (bus),
    .ic_inst_o      (ic_inst),
    .stallreq_ic_o  (stallreq)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [64:0] mkbus(input logic [31:0] exc, input logic ce, input logic [31:0] pc);
    return {exc, ce, pc};
  endfunction

  initial begin
    rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'h0; br_e = 1'b0;
    br_addr = 32'h0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {64'h0, inst_req}, 65'h0);
    chk("rst_stallreq", {64'h0, stallreq}, 65'h0);
    chk("rst_bus", bus, 65'h0);

    // First fetch right after reset release, best-case handshake.
    rst = 1'b0;
    #1;
    chk("first_req", {64'h0, inst_req}, 65'h1);
    chk("first_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0000});
    chk("first_stallreq", {64'h0, stallreq}, 65'h1);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2408_0001;
    chk("wd_req_low", {64'h0, inst_req}, 65'h0);
    tick();
    data_ok = 1'b0;
    chk("done_bus", bus, mkbus(32'h0, 1'b1, 32'hBFC0_0000));
    chk("done_inst", {33'h0, ic_inst}, {33'h0, 32'h2408_0001});
    chk("done_stallreq", {64'h0, stallreq}, 65'h0);

    // Downstream stall holds the item.
    stall = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_bus", bus, mkbus(32'h0, 1'b1, 32'hBFC0_0000));
      chk("stall_inst", {33'h0, ic_inst}, {33'h0, 32'h2408_0001});
      chk("stall_noreq", {64'h0, inst_req}, 65'h0);
    end
    stall = 6'b000000;
    tick();
    chk("next_req", {64'h0, inst_req}, 65'h1);
    chk("next_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0004});

    // Address acceptance delayed four cycles.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wa_req", {64'h0, inst_req}, 65'h1);
      chk("wa_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0004});
      chk("wa_stallreq", {64'h0, stallreq}, 65'h1);
    end
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3C01_1234;
    tick();
    data_ok = 1'b0;
    chk("wa_done_bus", bus, mkbus(32'h0, 1'b1, 32'hBFC0_0004));
    chk("wa_done_inst", {33'h0, ic_inst}, {33'h0, 32'h3C01_1234});
    tick();
    chk("seq_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0008});

    // Flush during WAIT_DATA discards the returning data.
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; flush = 1'b1; new_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    chk("flush_wd_ce", {64'h0, bus[32]}, 65'h0);
    tick();
    chk("flush_drop_ce", {64'h0, bus[32]}, 65'h0);
    chk("flush_req", {64'h0, inst_req}, 65'h1);
    chk("flush_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0380});

    // data_ok outside WAIT_DATA is ignored.
    tick();
    data_ok = 1'b0;
    chk("spur_req", {64'h0, inst_req}, 65'h1);
    chk("spur_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0380});
    chk("spur_ce", {64'h0, bus[32]}, 65'h0);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0000_000C;
    tick();
    data_ok = 1'b0;
    chk("flush_done_bus", bus, mkbus(32'h0, 1'b1, 32'hBFC0_0380));

    // Branch to a misaligned target while the current item is held.
    stall = 6'b000010; br_e = 1'b1; br_addr = 32'hBFC0_0102;
    tick();
    br_e = 1'b0;
    chk("br_keep_bus", bus, mkbus(32'h0, 1'b1, 32'hBFC0_0380));
    chk("br_keep_inst", {33'h0, ic_inst}, {33'h0, 32'h0000_000C});
    stall = 6'b000000;
    tick();
    chk("adel_idle_noreq", {64'h0, inst_req}, 65'h0);
    chk("adel_idle_stallreq", {64'h0, stallreq}, 65'h1);
    stall = 6'b000010;
    tick();
    chk("adel_bus", bus, mkbus(32'h0000_0010, 1'b1, 32'hBFC0_0102));
    chk("adel_inst", {33'h0, ic_inst}, 65'h0);
    chk("adel_noreq", {64'h0, inst_req}, 65'h0);

    // Flush and branch together: flush wins and drops the buffered item.
    flush = 1'b1; new_pc = 32'hBFC0_0200; br_e = 1'b1; br_addr = 32'hBFC0_0300;
    tick();
    flush = 1'b0; br_e = 1'b0; stall = 6'b000000;
    chk("fb_ce", {64'h0, bus[32]}, 65'h0);
    chk("fb_req", {64'h0, inst_req}, 65'h1);
    chk("fb_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0200});
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1234_5678;
    tick();
    data_ok = 1'b0;
    chk("fb_done_bus", bus, mkbus(32'h0, 1'b1, 32'hBFC0_0200));
    tick();
    chk("fb_next_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0204});

    // Reset in the middle of a transaction.
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_req", {64'h0, inst_req}, 65'h0);
    chk("mid_rst_stallreq", {64'h0, stallreq}, 65'h0);
    tick();
    rst = 1'b0; data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("post_rst_addr", {33'h0, inst_addr}, {33'h0, 32'hBFC0_0000});
    tick();
    data_ok = 1'b0;
    chk("post_rst_ce", {64'h0, bus[32]}, 65'h0);
    chk("post_rst_req", {64'h0, inst_req}, 65'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
